// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: multi-lane dispatch, CDB wakeup, oldest-first issue, branch squash.
// Optional feature macro RS_DISP_BYPASS_EN: dispatching entries capture same-cycle CDB tags.
module rs_age_ordered #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DISP_W    = 2,
  parameter int unsigned ISSUE_W   = 2,
  parameter int unsigned CDB_W     = 2,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned BMASK_W   = 4,
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [$clog2(DISP_W+1)-1:0]   disp_num,
  input  logic [DISP_W*TAG_W-1:0]       disp_src1_tag,
  input  logic [DISP_W-1:0]             disp_src1_rdy,
  input  logic [DISP_W*TAG_W-1:0]       disp_src2_tag,
  input  logic [DISP_W-1:0]             disp_src2_rdy,
  input  logic [DISP_W*BMASK_W-1:0]     disp_bmask,
  input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload,
  output logic [$clog2(DISP_W+1)-1:0]   free_spots,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]        cdb_tag,
  output logic [ISSUE_W-1:0]            iss_valid,
  input  logic [ISSUE_W-1:0]            iss_ready,
  output logic [ISSUE_W*PAYLOAD_W-1:0]  iss_payload,
  output logic [ISSUE_W*BMASK_W-1:0]    iss_bmask,
  input  logic [BMASK_W-1:0]            br_resolve_mask,
  input  logic                          br_mispred
);

  localparam int unsigned DN_W = $clog2(DISP_W + 1);
  localparam int unsigned OC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     src1_rdy_q, src1_rdy_d;
  logic [DEPTH-1:0]     src2_rdy_q, src2_rdy_d;
  logic [TAG_W-1:0]     src1_tag_q [DEPTH];
  logic [TAG_W-1:0]     src1_tag_d [DEPTH];
  logic [TAG_W-1:0]     src2_tag_q [DEPTH];
  logic [TAG_W-1:0]     src2_tag_d [DEPTH];
  logic [BMASK_W-1:0]   bmask_q    [DEPTH];
  logic [BMASK_W-1:0]   bmask_d    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d  [DEPTH];
  // age_q[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0]     age_q      [DEPTH];
  logic [DEPTH-1:0]     age_d      [DEPTH];

  logic [DEPTH-1:0]     killed_c, elig_c, issued_c;
  logic [OC_W-1:0]      rank_c [DEPTH];
  logic [OC_W-1:0]      occ_c, free_c;
  logic [DEPTH-1:0]     new_mask_c;
  logic [OC_W-1:0]      seen_c;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]       tag,
                                   input logic [CDB_W-1:0]       vld,
                                   input logic [CDB_W*TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int unsigned c = 0; c < CDB_W; c++)
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) cdb_hit = 1'b1;
  endfunction

  // Capacity from registered valid bits only
  always_comb begin
    occ_c      = OC_W'($countones(valid_q));
    free_c     = OC_W'(DEPTH) - occ_c;
    occupancy  = occ_c;
    free_spots = (free_c >= OC_W'(DISP_W)) ? DN_W'(DISP_W) : DN_W'(free_c);
  end

  // Eligibility and age rank: rank = number of older eligible entries
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      killed_c[i] = br_mispred && valid_q[i] && (|(bmask_q[i] & br_resolve_mask));
      elig_c[i]   = valid_q[i] && src1_rdy_q[i] && src2_rdy_q[i] && !killed_c[i];
    end
    for (int unsigned i = 0; i < DEPTH; i++)
      rank_c[i] = OC_W'($countones(elig_c & age_q[i]));
  end

  // Lane k carries the eligible entry of rank k
  always_comb begin
    iss_valid   = '0;
    iss_payload = '0;
    iss_bmask   = '0;
    issued_c    = '0;
    for (int unsigned k = 0; k < ISSUE_W; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (elig_c[i] && (rank_c[i] == OC_W'(k))) begin
          iss_valid[k]                          = 1'b1;
          iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
          iss_bmask[k*BMASK_W +: BMASK_W]       = bmask_q[i] & ~br_resolve_mask;
          if (iss_ready[k]) issued_c[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q;
    src2_rdy_d = src2_rdy_q;
    src1_tag_d = src1_tag_q;
    src2_tag_d = src2_tag_q;
    bmask_d    = bmask_q;
    payload_d  = payload_q;
    age_d      = age_q;
    new_mask_c = '0;
    seen_c     = '0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      bmask_d[i] = bmask_q[i] & ~br_resolve_mask;
      if (cdb_hit(src1_tag_q[i], cdb_valid, cdb_tag)) src1_rdy_d[i] = 1'b1;
      if (cdb_hit(src2_tag_q[i], cdb_valid, cdb_tag)) src2_rdy_d[i] = 1'b1;
      if (killed_c[i] || issued_c[i]) valid_d[i] = 1'b0;
    end

    // Lane k fills the k-th registered-free slot; squashed lanes still consume their slot index
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) begin
        for (int unsigned k = 0; k < DISP_W; k++) begin
          if ((seen_c == OC_W'(k)) && (DN_W'(k) < disp_num) &&
              !(br_mispred && (|(disp_bmask[k*BMASK_W +: BMASK_W] & br_resolve_mask)))) begin
            valid_d[i]    = 1'b1;
            src1_tag_d[i] = disp_src1_tag[k*TAG_W +: TAG_W];
            src2_tag_d[i] = disp_src2_tag[k*TAG_W +: TAG_W];
`ifdef RS_DISP_BYPASS_EN
            src1_rdy_d[i] = disp_src1_rdy[k] | cdb_hit(disp_src1_tag[k*TAG_W +: TAG_W], cdb_valid, cdb_tag);
            src2_rdy_d[i] = disp_src2_rdy[k] | cdb_hit(disp_src2_tag[k*TAG_W +: TAG_W], cdb_valid, cdb_tag);
`else
            src1_rdy_d[i] = disp_src1_rdy[k];
            src2_rdy_d[i] = disp_src2_rdy[k];
`endif
            bmask_d[i]    = disp_bmask[k*BMASK_W +: BMASK_W] & ~br_resolve_mask;
            payload_d[i]  = disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
            for (int unsigned r = 0; r < DEPTH; r++) age_d[r][i] = 1'b0;
            age_d[i]      = valid_q | new_mask_c;
            new_mask_c[i] = 1'b1;
          end
        end
        seen_c = seen_c + OC_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        bmask_q[i]    <= '0;
        payload_q[i]  <= '0;
        age_q[i]      <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      src1_rdy_q <= src1_rdy_d;
      src2_rdy_q <= src2_rdy_d;
      src1_tag_q <= src1_tag_d;
      src2_tag_q <= src2_tag_d;
      bmask_q    <= bmask_d;
      payload_q  <= payload_d;
      age_q      <= age_d;
    end
  end

  disp_overflow_a: assert property (@(posedge clock) disable iff (reset) disp_num <= free_spots);

endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: directed steps then random traffic against an age-ordered queue model.
module tb_rs_age_ordered;
  localparam int DEPTH = 8, DISP_W = 2, ISSUE_W = 2, CDB_W = 2;
  localparam int TAG_W = 6, BMASK_W = 4, PAYLOAD_W = 32;
`ifdef RS_DISP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                         clock, reset;
  logic [1:0]                   disp_num;
  logic [DISP_W*TAG_W-1:0]      disp_src1_tag, disp_src2_tag;
  logic [DISP_W-1:0]            disp_src1_rdy, disp_src2_rdy;
  logic [DISP_W*BMASK_W-1:0]    disp_bmask;
  logic [DISP_W*PAYLOAD_W-1:0]  disp_payload;
  logic [1:0]                   free_spots;
  logic [3:0]                   occupancy;
  logic [CDB_W-1:0]             cdb_valid;
  logic [CDB_W*TAG_W-1:0]       cdb_tag;
  logic [ISSUE_W-1:0]           iss_valid, iss_ready;
  logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload;
  logic [ISSUE_W*BMASK_W-1:0]   iss_bmask;
  logic [BMASK_W-1:0]           br_resolve_mask;
  logic                         br_mispred;

  rs_age_ordered dut (
    .clock(clock), .reset(reset), .disp_num(disp_num),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_bmask(disp_bmask), .disp_payload(disp_payload),
    .free_spots(free_spots), .occupancy(occupancy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_payload(iss_payload), .iss_bmask(iss_bmask),
    .br_resolve_mask(br_resolve_mask), .br_mispred(br_mispred)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: live entries kept oldest-first
  typedef struct {
    logic [TAG_W-1:0]     t1;
    logic                 r1;
    logic [TAG_W-1:0]     t2;
    logic                 r2;
    logic [BMASK_W-1:0]   bm;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;
  ent_t mq[$];

  int          n_chk, n_err, cyc;
  logic [31:0] pay_ctr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic hit(input logic [TAG_W-1:0] t);
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == t)) hit = 1'b1;
  endfunction

  task automatic idle();
    disp_num        = '0;
    cdb_valid       = '0;
    iss_ready       = 2'b11;
    br_resolve_mask = '0;
    br_mispred      = 1'b0;
  endtask

  task automatic lane(input int k, input logic [TAG_W-1:0] t1, input logic r1,
                      input logic [TAG_W-1:0] t2, input logic r2, input logic [BMASK_W-1:0] bm);
    disp_src1_tag[k*TAG_W +: TAG_W]         = t1;
    disp_src1_rdy[k]                        = r1;
    disp_src2_tag[k*TAG_W +: TAG_W]         = t2;
    disp_src2_rdy[k]                        = r2;
    disp_bmask[k*BMASK_W +: BMASK_W]        = bm;
    disp_payload[k*PAYLOAD_W +: PAYLOAD_W]  = pay_ctr;
    pay_ctr                                 = pay_ctr + 32'd1;
  endtask

  task automatic cdb(input int c, input logic [TAG_W-1:0] t);
    cdb_valid[c]                = 1'b1;
    cdb_tag[c*TAG_W +: TAG_W]   = t;
  endtask

  // Check outputs against the model mid-cycle, then advance the model across the edge
  task automatic step();
    int   n, free;
    int   sel [ISSUE_W];
    logic [ISSUE_W-1:0] exp_iv;
    logic [BMASK_W-1:0] rm;
    logic kill, gone;
    ent_t nq[$];
    ent_t e;
    #2;
    rm   = br_resolve_mask;
    free = DEPTH - mq.size();
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("free_spots", 64'(free_spots), 64'((free < DISP_W) ? free : DISP_W));
    exp_iv = '0;
    n = 0;
    for (int k = 0; k < ISSUE_W; k++) sel[k] = -1;
    for (int i = 0; i < mq.size(); i++) begin
      kill = br_mispred && ((mq[i].bm & rm) != '0);
      if (mq[i].r1 && mq[i].r2 && !kill) begin
        if (n < ISSUE_W) begin
          exp_iv[n] = 1'b1;
          sel[n]    = i;
        end
        n++;
      end
    end
    chk("iss_valid", 64'(iss_valid), 64'(exp_iv));
    for (int k = 0; k < ISSUE_W; k++) begin
      if (exp_iv[k]) begin
        chk($sformatf("iss_payload%0d", k), 64'(iss_payload[k*PAYLOAD_W +: PAYLOAD_W]), 64'(mq[sel[k]].pl));
        chk($sformatf("iss_bmask%0d", k), 64'(iss_bmask[k*BMASK_W +: BMASK_W]), 64'(mq[sel[k]].bm & ~rm));
      end
    end
    if (reset) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        gone = br_mispred && ((mq[i].bm & rm) != '0);
        for (int k = 0; k < ISSUE_W; k++)
          if (exp_iv[k] && (sel[k] == i) && iss_ready[k]) gone = 1'b1;
        if (!gone) begin
          e    = mq[i];
          e.r1 = e.r1 | hit(e.t1);
          e.r2 = e.r2 | hit(e.t2);
          e.bm = e.bm & ~rm;
          nq.push_back(e);
        end
      end
      for (int k = 0; k < DISP_W; k++) begin
        if ((k >= int'(disp_num)) || (k >= free)) break;
        e.bm = disp_bmask[k*BMASK_W +: BMASK_W];
        if (br_mispred && ((e.bm & rm) != '0)) continue;
        e.bm = e.bm & ~rm;
        e.t1 = disp_src1_tag[k*TAG_W +: TAG_W];
        e.t2 = disp_src2_tag[k*TAG_W +: TAG_W];
        e.r1 = disp_src1_rdy[k] | (BYPASS & hit(e.t1));
        e.r2 = disp_src2_rdy[k] | (BYPASS & hit(e.t2));
        e.pl = disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
        nq.push_back(e);
      end
      mq = nq;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int f;
    n_chk = 0; n_err = 0; cyc = 0; pay_ctr = 32'h100;
    reset = 1'b1;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
    disp_bmask = '0; disp_payload = '0; cdb_tag = '0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_free_spots", 64'(free_spots), 64'd2);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    step();

    // A alone, then B and C together; A issues first, then B on lane 0 and C on lane 1
    idle(); disp_num = 2'd1; lane(0, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0000); step();
    idle(); disp_num = 2'd2; lane(0, 6'd1, 1'b1, 6'd2, 1'b1, 4'b0000);
    lane(1, 6'd3, 1'b1, 6'd4, 1'b1, 4'b0000); step();
    idle(); step();
    idle(); chk("drain_occupancy", 64'(occupancy), 64'd0); step();

    // D waits on tag 5; broadcast, then it issues the cycle after
    idle(); disp_num = 2'd1; lane(0, 6'd5, 1'b0, 6'd6, 1'b1, 4'b0000); step();
    idle(); cdb(0, 6'd5); step();
    idle(); step();
    idle(); step();

    // Fill all entries with unready sources
    for (int c = 0; c < 4; c++) begin
      idle(); disp_num = 2'd2;
      lane(0, 6'(16 + 4*c), 1'b0, 6'(17 + 4*c), 1'b0, 4'b0000);
      lane(1, 6'(18 + 4*c), 1'b0, 6'(19 + 4*c), 1'b0, 4'b0000);
      step();
    end
    idle(); iss_ready = 2'b00; chk("full_free_spots", 64'(free_spots), 64'd0);
    cdb(0, 6'd16); cdb(1, 6'd17); step();
    idle(); iss_ready = 2'b00; step();
    idle(); iss_ready = 2'b00; step();
    idle(); iss_ready = 2'b01; step();
    idle(); iss_ready = 2'b00; chk("after_issue_free_spots", 64'(free_spots), 64'd1); step();
    for (int t = 18; t < 32; t += 2) begin
      idle(); cdb(0, 6'(t)); cdb(1, 6'(t + 1)); step();
    end
    for (int c = 0; c < 4; c++) begin idle(); step(); end

    // Mispredict kills the 0010 entry; a correct resolve clears 0100 from the survivor
    idle(); disp_num = 2'd2;
    lane(0, 6'd40, 1'b0, 6'd1, 1'b1, 4'b0010);
    lane(1, 6'd41, 1'b0, 6'd1, 1'b1, 4'b0100); step();
    idle(); cdb(0, 6'd40); step();
    idle(); br_resolve_mask = 4'b0010; br_mispred = 1'b1; step();
    idle(); chk("squash_occupancy", 64'(occupancy), 64'd1); br_resolve_mask = 4'b0100; step();
    idle(); cdb(0, 6'd41); step();
    idle(); step();
    idle(); step();

    // E's src2 tag is broadcast in its dispatch cycle
    idle(); disp_num = 2'd1; lane(0, 6'd1, 1'b1, 6'd9, 1'b0, 4'b0000); cdb(0, 6'd9); step();
    idle(); step();
    idle(); cdb(0, 6'd9); step();
    idle(); step();
    idle(); step();

    // Random traffic with one mid-run reset
    for (int it = 0; it < 400; it++) begin
      idle();
      f = DEPTH - mq.size();
      if (f > DISP_W) f = DISP_W;
      disp_num = 2'($urandom_range(0, f));
      for (int k = 0; k < DISP_W; k++)
        lane(k, 6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      for (int c = 0; c < CDB_W; c++)
        if ($urandom_range(0, 1) == 1) cdb(c, 6'($urandom_range(0, 15)));
      iss_ready = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        br_resolve_mask = 4'(1 << $urandom_range(0, 3));
        br_mispred      = ($urandom_range(0, 2) == 0);
      end
      reset = (it == 200);
      step();
      reset = 1'b0;
      if (it == 200) chk("midreset_occupancy", 64'(occupancy), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
Parametrised reservation station: successor to the fixed-width RS.
- Accepts up to DISP_W renamed instructions per cycle.
- Wakes up source operands from CDB_W broadcast tags.
- Selects up to ISSUE_W ready entries per cycle, oldest first, using an internal age matrix.
- Sits between dispatch and the functional-unit issue lanes; handles branch-mask resolve and mispredict squash.

Parameters:
DEPTH, 8, number of entries
DISP_W, 2, dispatch lanes per cycle
ISSUE_W, 2, issue lanes per cycle
CDB_W, 2, CDB broadcast tags per cycle
TAG_W, 6, physical register tag width
BMASK_W, 4, branch mask width
PAYLOAD_W, 32, opaque per-entry payload width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
disp_num  in  $clog2(DISP_W+1)  number of valid dispatch lanes; lanes 0..disp_num-1 valid
disp_src1_tag  in  DISP_W*TAG_W  source 1 tag per lane
disp_src1_rdy  in  DISP_W  source 1 already ready
disp_src2_tag  in  DISP_W*TAG_W  source 2 tag per lane
disp_src2_rdy  in  DISP_W  source 2 already ready
disp_bmask  in  DISP_W*BMASK_W  branch mask per lane
disp_payload  in  DISP_W*PAYLOAD_W  payload per lane
free_spots  out  $clog2(DISP_W+1)  min(free entries, DISP_W)
occupancy  out  $clog2(DEPTH+1)  valid entry count
cdb_valid  in  CDB_W  broadcast valid
cdb_tag  in  CDB_W*TAG_W  broadcast tags
iss_valid  out  ISSUE_W  lane carries a selected entry
iss_ready  in  ISSUE_W  FU lane accepts
iss_payload  out  ISSUE_W*PAYLOAD_W  selected payload
iss_bmask  out  ISSUE_W*BMASK_W  selected branch mask, resolved bits already cleared
br_resolve_mask  in  BMASK_W  one-hot branch resolving this cycle (0 = none)
br_mispred  in  1  resolving branch mispredicted

Behaviour:
Reset:
- All entries invalid; age matrix cleared.
- Outputs after reset: free_spots=min(DEPTH,DISP_W), occupancy=0, iss_valid=0.

Capacity outputs:
- free_spots and occupancy are combinational from registered valid bits only.
- A slot freed by issue or squash in cycle t is usable from t+1.

Dispatch:
- Lane k (k<disp_num) writes the k-th lowest-index free slot.
- Slot state: valid=1, tags, rdy bits, bmask, payload.
- disp_num>free_spots is illegal; flagged by assertion, entries beyond free_spots are dropped.

Age ordering:
- Entries dispatched in cycle t are older than all entries dispatched after t.
- Within one cycle, lower lane is older.
- Age matrix row of a new entry is set to "younger than" every currently valid entry and every lower-lane entry written the same cycle.

Wakeup:
- Any valid CDB tag matching a valid entry's src tag sets that rdy bit at the next edge.
- Entry becomes issue-eligible the cycle after the broadcast.
- Incoming dispatch entries are not matched against same-cycle CDB tags unless RS_DISP_BYPASS_EN is defined.

Selection (combinational):
- Eligible = valid & src1_rdy & src2_rdy & not killed this cycle.
- Issue lane k presents the k-th oldest eligible entry; iss_valid[k]=0 if fewer than k+1 are eligible.
- An entry leaves the RS when iss_valid[k] & iss_ready[k]; otherwise it stays and may be re-selected next cycle in any lane.

Branch resolve:
- br_resolve_mask bits are cleared from every stored bmask, from incoming dispatch bmasks, and from iss_bmask outputs in the same cycle.

Mispredict (br_mispred=1):
- Killed = valid entries, and incoming dispatch entries, whose bmask & br_resolve_mask != 0.
- Killed entries are invalid at the next edge and never presented on iss_valid in the kill cycle.
- Squash overrides issue, wakeup and dispatch.

Simultaneous events:
- Issue and wakeup of other entries in the same cycle are independent.
- Dispatch into a slot never collides with that slot's issue, because only registered-free slots are written.

Mid-operation reset: all state is cleared at the edge, regardless of any concurrent inputs.

Optional Feature:
RS_DISP_BYPASS_EN
- Defined: dispatching entries whose src tag matches a same-cycle valid CDB tag are written with that rdy bit set, so no wakeup is lost at dispatch.
- Undefined: dispatch must supply correct rdy bits itself; CDB tags in the dispatch cycle are ignored for incoming entries.

Test Plan:
- Reset, then idle: free_spots=2, occupancy=0, iss_valid=00.
- Dispatch A (cycle 1), then B and C (cycle 2), all sources ready, iss_ready=11: cycle 2 issues A on lane 0; cycle 3 issues B on lane 0 and C on lane 1; occupancy returns to 0.
- Dispatch D with src1 tag 5 not ready; cdb tag 5 valid in cycle 3: D is not selectable in cycle 3, is issued in cycle 4 (without bypass).
- Fill all 8 entries, none ready: free_spots=0. Broadcast both tags of the oldest entry, hold iss_ready=00 for 2 cycles, then 01: the oldest issues on lane 0 and free_spots=1 next cycle.
- Entries with bmask 0010 and 0100; br_resolve_mask=0010, br_mispred=1: the 0010 entry never issues and occupancy drops by 1. Then mask 0100 with br_mispred=0: the stored bmask becomes 0000 and the entry is retained.
- With RS_DISP_BYPASS_EN: dispatch E with src2 tag 9 while cdb tag 9 is valid the same cycle: E is issued the next cycle.
